fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the register file. It owns the program counter and issues one instruction-memory request at a time. Each returned instruction is held in the IF/ID pipeline register, and the stage drives the register file read addresses (rr1, rr2) from the rs/rt fields of that register. The stage supports decode stalls (via a one-entry skid buffer) and branch/jump redirects (via a flush).

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_skid_buf.sv | 64 ++++++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// instruction field positions used to drive the register file read ports,
// the NOP encoding and a word-alignment helper.
package fetch_pkg;

   localparam int INSTR_W = 32;

   // Source register fields of an instruction word
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   // Forces the two byte-offset bits of an address to zero
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry buffer holding an {instruction, pc+4} pair that arrived while
// decode was stalled.
// Ports:
//   clock, resetn          : clock and synchronous active-low reset
//   load                   : capture load_instr/load_pc4, mark full
//   unload                 : entry consumed, mark empty
//   clear                  : discard entry (takes priority over load/unload)
//   load_instr, load_pc4   : data to capture
//   valid, instr, pc4      : registered buffer contents
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic               clock,
   input  logic               resetn,
   input  logic               load,
   input  logic               unload,
   input  logic               clear,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [31:0]        load_pc4,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        pc4
);

   logic               valid_q, valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [31:0]        pc4_q, pc4_d;

   // Clear wipes the data as well so a discarded instruction can never leak
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      if (clear) begin
         valid_d = 1'b0;
         instr_d = INSTR_NOP;
         pc4_d   = 32'h0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = load_instr;
         pc4_d   = load_pc4;
      end else if (unload) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         instr_q <= INSTR_NOP;
         pc4_q   <= 32'h0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid = valid_q;
   assign instr = instr_q;
   assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage: owns the PC, issues one instruction-memory request
// at a time, holds the returned instruction in the IF/ID register and drives
// the register file read addresses from its rs/rt fields.
// Ports:
//   clock, resetn             : clock and synchronous active-low reset
//   imem_req/imem_addr        : fetch request and word-aligned address (= pc)
//   imem_ready/imem_rdata     : same-cycle accept and instruction data
//   stall                     : decode cannot accept, IF/ID holds
//   redirect/redirect_pc      : taken branch/jump, flush and refetch
//   id_valid/id_instr/id_pc4  : IF/ID register contents
//   rr1/rr2                   : rs/rt fields of id_instr
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic               clock,
   input  logic               resetn,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [31:0]        id_pc4,
   output logic [4:0]         rr1,
   output logic [4:0]         rr2
);

   fetch_state_e       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               req_q, req_d;
   logic               id_valid_q, id_valid_d;
   logic [INSTR_W-1:0] id_instr_q, id_instr_d;
   logic [31:0]        id_pc4_q, id_pc4_d;

   logic               skid_load, skid_unload, skid_clear;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [31:0]        skid_pc4;

   logic [31:0]        pc_plus4;
   logic               transfer;

   fetch_skid_buf u_skid (
      .clock      (clock),
      .resetn     (resetn),
      .load       (skid_load),
      .unload     (skid_unload),
      .clear      (skid_clear),
      .load_instr (imem_rdata),
      .load_pc4   (pc_plus4),
      .valid      (skid_valid),
      .instr      (skid_instr),
      .pc4        (skid_pc4)
   );

   // Addition wraps naturally at 2^32
   assign pc_plus4 = pc_q + 32'd4;
   assign transfer = (state_q == FETCH) && imem_ready;

   // Next-state, PC and IF/ID update. Redirect overrides everything,
   // including a transfer and a stall in the same cycle.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      id_valid_d  = id_valid_q;
      id_instr_d  = id_instr_q;
      id_pc4_d    = id_pc4_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;

      if (redirect) begin
         pc_d       = word_align(redirect_pc);
         id_valid_d = 1'b0;
         skid_clear = 1'b1;
         state_d    = FETCH;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = FETCH;
            end
            FETCH: begin
               if (transfer) begin
                  pc_d = pc_plus4;
                  if (stall) begin
                     skid_load = 1'b1;
                     state_d   = HOLD;
                  end else begin
                     id_valid_d = 1'b1;
                     id_instr_d = imem_rdata;
                     id_pc4_d   = pc_plus4;
                  end
               end else if (!stall) begin
                  // Bubble: only the valid bit drops, payload is kept
                  id_valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  id_valid_d  = skid_valid;
                  id_instr_d  = skid_instr;
                  id_pc4_d    = skid_pc4;
                  skid_unload = 1'b1;
                  state_d     = FETCH;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // The request is registered so imem_req comes straight from a flop
      req_d = (state_d == FETCH);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         id_valid_q <= 1'b0;
         id_instr_q <= INSTR_NOP;
         id_pc4_q   <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc4_q   <= id_pc4_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc4    = id_pc4_q;
   assign rr1       = id_instr_q[RS_MSB:RS_LSB];
   assign rr2       = id_instr_q[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Two fetch stages (RESET_PC 0x100 and 0xFFFF_FFFC) share one stimulus
// stream. A behavioural model tracks what each should present every cycle;
// a negedge compare process checks all outputs, and a few literal values
// pin the model to hand-worked results.
module tb_fetch_stage;

   localparam logic [31:0] DATA_MASK = 32'hA5A5_0000;
   localparam logic [31:0] RST_PC0   = 32'h0000_0100;
   localparam logic [31:0] RST_PC1   = 32'hFFFF_FFFC;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        imem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = 32'h0;

   logic        imem_req  [2];
   logic [31:0] imem_addr [2];
   logic [31:0] imem_rdata[2];
   logic        id_valid  [2];
   logic [31:0] id_instr  [2];
   logic [31:0] id_pc4    [2];
   logic [4:0]  rr1       [2];
   logic [4:0]  rr2       [2];

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   always #5 clock = ~clock;

   // Memory returns address-derived data unless a directed test overrides it
   assign imem_rdata[0] = ovr_en ? ovr_data : (imem_addr[0] ^ DATA_MASK);
   assign imem_rdata[1] = ovr_en ? ovr_data : (imem_addr[1] ^ DATA_MASK);

   fetch_stage #(.RESET_PC(RST_PC0)) dut0 (
      .clock(clock), .resetn(resetn),
      .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata[0]),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid[0]), .id_instr(id_instr[0]), .id_pc4(id_pc4[0]),
      .rr1(rr1[0]), .rr2(rr2[0])
   );

   fetch_stage #(.RESET_PC(RST_PC1)) dut1 (
      .clock(clock), .resetn(resetn),
      .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata[1]),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid[1]), .id_instr(id_instr[1]), .id_pc4(id_pc4[1]),
      .rr1(rr1[1]), .rr2(rr2[1])
   );

   // Behavioural model: "started" means the first post-reset edge has passed,
   // and a parked instruction in the skid pauses requests until decode drains it.
   logic [31:0] m_pc       [2];
   bit          m_started  [2];
   bit          m_valid    [2];
   logic [31:0] m_instr    [2];
   logic [31:0] m_pc4      [2];
   bit          m_parked   [2];
   logic [31:0] m_par_instr[2];
   logic [31:0] m_par_pc4  [2];

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (!resetn) begin
            m_pc[i]      = (i == 0) ? RST_PC0 : RST_PC1;
            m_started[i] = 1'b0;
            m_valid[i]   = 1'b0;
            m_instr[i]   = 32'h0;
            m_pc4[i]     = 32'h0;
            m_parked[i]  = 1'b0;
         end else if (redirect) begin
            m_pc[i]      = {redirect_pc[31:2], 2'b00};
            m_started[i] = 1'b1;
            m_valid[i]   = 1'b0;
            m_parked[i]  = 1'b0;
         end else if (!m_started[i]) begin
            m_started[i] = 1'b1;
         end else if (m_parked[i]) begin
            if (!stall) begin
               m_valid[i]  = 1'b1;
               m_instr[i]  = m_par_instr[i];
               m_pc4[i]    = m_par_pc4[i];
               m_parked[i] = 1'b0;
            end
         end else if (imem_ready) begin
            if (stall) begin
               m_parked[i]    = 1'b1;
               m_par_instr[i] = imem_rdata[i];
               m_par_pc4[i]   = m_pc[i] + 32'd4;
            end else begin
               m_valid[i] = 1'b1;
               m_instr[i] = imem_rdata[i];
               m_pc4[i]   = m_pc[i] + 32'd4;
            end
            m_pc[i] = m_pc[i] + 32'd4;
         end else if (!stall) begin
            m_valid[i] = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t",
                  name, idx, act, exp, $time);
      end
   endtask

   // Compare every output of both instances against the model each cycle
   always @(negedge clock) begin
      if (check_en) begin
         for (int i = 0; i < 2; i++) begin
            checkOutput("imem_req", i, 32'(imem_req[i]),
                        32'(m_started[i] && !m_parked[i]));
            checkOutput("imem_addr", i, imem_addr[i], m_pc[i]);
            checkOutput("id_valid", i, 32'(id_valid[i]), 32'(m_valid[i]));
            checkOutput("id_instr", i, id_instr[i], m_instr[i]);
            checkOutput("id_pc4", i, id_pc4[i], m_pc4[i]);
            checkOutput("rr1", i, 32'(rr1[i]), 32'(m_instr[i][25:21]));
            checkOutput("rr2", i, 32'(rr2[i]), 32'(m_instr[i][20:16]));
         end
      end
   end

   // Drive one cycle worth of inputs, then wait for the following negedge
   task automatic applyStimulus(input bit rstn, input bit rdy, input bit stl,
                                input bit rdir, input logic [31:0] rpc);
      resetn      = rstn;
      imem_ready  = rdy;
      stall       = stl;
      redirect    = rdir;
      redirect_pc = rpc;
      @(negedge clock);
   endtask

   initial begin
      $display("[TB] start");
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_en = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

      // Reset values
      checkOutput("rst_req", 0, 32'(imem_req[0]), 32'h0);
      checkOutput("rst_valid", 0, 32'(id_valid[0]), 32'h0);
      checkOutput("rst_instr", 0, id_instr[0], 32'h0);
      checkOutput("rst_addr", 0, imem_addr[0], 32'h100);

      // Stream at full rate
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("first_addr", 0, imem_addr[0], 32'h100);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stream_pc4_a", 0, id_pc4[0], 32'h104);
      checkOutput("stream_instr", 0, id_instr[0], 32'hA5A5_0100);
      checkOutput("wrap_pc4", 1, id_pc4[1], 32'h0);
      checkOutput("wrap_addr", 1, imem_addr[1], 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stream_pc4_b", 0, id_pc4[0], 32'h108);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stream_pc4_c", 0, id_pc4[0], 32'h10C);
      checkOutput("stream_valid", 0, 32'(id_valid[0]), 32'h1);

      // Slow memory: ready every third cycle
      for (int c = 0; c < 12; c++)
         applyStimulus(1'b1, (c % 3) == 2, 1'b0, 1'b0, 32'h0);

      // Stall starting at a transfer of a known instruction
      ovr_en   = 1'b1;
      ovr_data = 32'h0123_4567;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      ovr_en = 1'b0;
      checkOutput("hold_req", 0, 32'(imem_req[0]), 32'h0);
      for (int c = 0; c < 3; c++)
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("unstall_instr", 0, id_instr[0], 32'h0123_4567);
      checkOutput("unstall_rr1", 0, 32'(rr1[0]), 32'h09);
      checkOutput("unstall_rr2", 0, 32'(rr2[0]), 32'h03);

      // Redirect while parked in HOLD
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h2003);
      checkOutput("redir_addr", 0, imem_addr[0], 32'h2000);
      checkOutput("redir_valid", 0, 32'(id_valid[0]), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("redir_pc4", 0, id_pc4[0], 32'h2004);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

      // Reset for one cycle while in HOLD
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("midrst_valid", 0, 32'(id_valid[0]), 32'h0);
      checkOutput("midrst_req", 0, 32'(imem_req[0]), 32'h0);
      checkOutput("midrst_pc4", 0, id_pc4[0], 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("restart_addr", 0, imem_addr[0], 32'h100);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         applyStimulus(($urandom % 64) != 0,
                       ($urandom % 4) != 0,
                       ($urandom % 4) == 0,
                       ($urandom % 16) == 0,
                       $urandom);
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
